// File: rtl/mem_wb_buf.sv
// MEM/WB stage buffer: DEPTH-entry FIFO with valid/ready on both sides.
// Carries GPR and HI/LO write bundles; write enables are masked when the head is empty.
module mem_wb_buf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic              mem_wreg,
   input  logic              mem_whilo,
   input  logic [DATA_W-1:0] mem_hi,
   input  logic [DATA_W-1:0] mem_lo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] wb_wdata,
   output logic [ADDR_W-1:0] wb_wd,
   output logic              wb_wreg,
   output logic              wb_whilo,
   output logic [DATA_W-1:0] wb_hi,
   output logic [DATA_W-1:0] wb_lo,
   output logic [CNT_W-1:0]  count
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] wd;
      logic              wreg;
      logic              whilo;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic             push, pop;

   // Handshake flags come only from the registered count, so neither side sees a comb loop.
   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= '{wdata: mem_wdata, wd: mem_wd, wreg: mem_wreg,
                          whilo: mem_whilo, hi: mem_hi, lo: mem_lo};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Stale entry contents are never visible: everything is masked by out_valid.
   always_comb begin
      head     = mem[rd_ptr];
      wb_wdata = '0;
      wb_wd    = '0;
      wb_wreg  = 1'b0;
      wb_whilo = 1'b0;
      wb_hi    = '0;
      wb_lo    = '0;
      if (out_valid) begin
         wb_wdata = head.wdata;
         wb_wd    = head.wd;
         wb_wreg  = head.wreg;
         wb_whilo = head.whilo;
         wb_hi    = head.hi;
         wb_lo    = head.lo;
      end
   end
endmodule

// File: tb/tb_mem_wb_buf.sv
// Bench for mem_wb_buf: vector table, hand-written corner sequences, and a
// random phase checked against a queue-based reference model.
module tb_mem_wb_buf;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0, rst = 1'b0, flush = 1'b0;
   logic              in_valid = 1'b0, out_ready = 1'b0;
   logic [DATA_W-1:0] mem_wdata = '0, mem_hi = '0, mem_lo = '0;
   logic [ADDR_W-1:0] mem_wd = '0;
   logic              mem_wreg = 1'b0, mem_whilo = 1'b0;
   logic              in_ready, out_valid, wb_wreg, wb_whilo;
   logic [DATA_W-1:0] wb_wdata, wb_hi, wb_lo;
   logic [ADDR_W-1:0] wb_wd;
   logic [CNT_W-1:0]  count;

   int total = 0;
   int bad   = 0;

   mem_wb_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .out_valid(out_valid), .out_ready(out_ready),
      .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] wd;
      logic              wreg;
      logic              whilo;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } bund_t;

   // Reference: the buffer is just a bounded in-order queue.
   bund_t q[$];

   typedef struct {
      logic        iv, orr, fl;
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic        wreg, whilo;
      logic [31:0] hi, lo;
      int          e_cnt;
      logic        e_ov, e_ir;
      logic [31:0] e_wdata;
      logic [4:0]  e_wd;
      logic        e_wreg, e_whilo;
      logic [31:0] e_hi, e_lo;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic orr, input logic fl, input bund_t b);
      in_valid  = iv;
      out_ready = orr;
      flush     = fl;
      mem_wdata = b.wdata;
      mem_wd    = b.wd;
      mem_wreg  = b.wreg;
      mem_whilo = b.whilo;
      mem_hi    = b.hi;
      mem_lo    = b.lo;
   endtask

   task automatic model_edge();
      bit    do_pop, do_push;
      bund_t cur;
      cur = '{wdata: mem_wdata, wd: mem_wd, wreg: mem_wreg, whilo: mem_whilo,
              hi: mem_hi, lo: mem_lo};
      if (!rst || flush) q.delete();
      else begin
         do_pop  = (q.size() != 0) && out_ready;
         do_push = in_valid && (q.size() != DEPTH);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(cur);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model(input string tag);
      bund_t h;
      h = (q.size() != 0) ? q[0] : '0;
      chk({tag, "_count"}, 64'(count), 64'(q.size()));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() != 0));
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() != DEPTH));
      chk({tag, "_wdata"}, 64'(wb_wdata), 64'(h.wdata));
      chk({tag, "_wd"}, 64'(wb_wd), 64'(h.wd));
      chk({tag, "_wreg"}, 64'(wb_wreg), 64'(h.wreg));
      chk({tag, "_whilo"}, 64'(wb_whilo), 64'(h.whilo));
      chk({tag, "_hi"}, 64'(wb_hi), 64'(h.hi));
      chk({tag, "_lo"}, 64'(wb_lo), 64'(h.lo));
   endtask

   initial begin
      bund_t b;
      int    nxt, got;
      logic  acc;

      //          iv orr fl wdata        wd wreg whilo hi  lo  | cnt ov ir wdata        wd wreg whilo hi            lo
      tbl[0]  = '{1, 1, 0, 32'hDEADBEEF, 9, 1, 0, 0, 0,            1, 1, 1, 32'hDEADBEEF, 9, 1, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0,            0, 0, 0, 0, 0,            0, 0, 1, 0,            0, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 32'h11,       1, 1, 0, 0, 0,            1, 1, 1, 32'h11,       1, 1, 0, 0, 0};
      tbl[3]  = '{1, 0, 0, 32'h22,       2, 1, 0, 0, 0,            2, 1, 1, 32'h11,       1, 1, 0, 0, 0};
      tbl[4]  = '{1, 0, 0, 32'h33,       3, 1, 0, 0, 0,            3, 1, 1, 32'h11,       1, 1, 0, 0, 0};
      tbl[5]  = '{1, 0, 0, 32'h44,       4, 1, 0, 0, 0,            4, 1, 0, 32'h11,       1, 1, 0, 0, 0};
      tbl[6]  = '{1, 0, 0, 32'h55,       5, 1, 0, 0, 0,            4, 1, 0, 32'h11,       1, 1, 0, 0, 0};
      tbl[7]  = '{1, 1, 0, 32'h55,       5, 1, 0, 0, 0,            3, 1, 1, 32'h22,       2, 1, 0, 0, 0};
      tbl[8]  = '{1, 0, 0, 32'h55,       5, 1, 0, 0, 0,            4, 1, 0, 32'h22,       2, 1, 0, 0, 0};
      tbl[9]  = '{0, 1, 0, 0,            0, 0, 0, 0, 0,            3, 1, 1, 32'h33,       3, 1, 0, 0, 0};
      tbl[10] = '{1, 1, 0, 32'h66,       6, 1, 0, 0, 0,            3, 1, 1, 32'h44,       4, 1, 0, 0, 0};
      tbl[11] = '{1, 1, 1, 32'h77,       7, 1, 1, 0, 0,            0, 0, 1, 0,            0, 0, 0, 0, 0};
      tbl[12] = '{0, 1, 0, 0,            0, 0, 0, 0, 0,            0, 0, 1, 0,            0, 0, 0, 0, 0};
      tbl[13] = '{1, 1, 0, 0,            0, 0, 1, 32'h12345678, 32'h9ABCDEF0,
                  1, 1, 1, 0,            0, 0, 1, 32'h12345678, 32'h9ABCDEF0};
      tbl[14] = '{0, 1, 0, 0,            0, 0, 0, 0, 0,            0, 0, 1, 0,            0, 0, 0, 0, 0};

      // Reset state
      #2;
      chk("rst_count", 64'(count), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_wb_wreg", 64'(wb_wreg), 0);
      tick();
      rst = 1'b1;

      // Vector table
      foreach (tbl[i]) begin
         b = '{wdata: tbl[i].wdata, wd: tbl[i].wd, wreg: tbl[i].wreg,
               whilo: tbl[i].whilo, hi: tbl[i].hi, lo: tbl[i].lo};
         drive(tbl[i].iv, tbl[i].orr, tbl[i].fl, b);
         tick();
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
         chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
         chk($sformatf("vec%0d_wdata", i), 64'(wb_wdata), 64'(tbl[i].e_wdata));
         chk($sformatf("vec%0d_wd", i), 64'(wb_wd), 64'(tbl[i].e_wd));
         chk($sformatf("vec%0d_wreg", i), 64'(wb_wreg), 64'(tbl[i].e_wreg));
         chk($sformatf("vec%0d_whilo", i), 64'(wb_whilo), 64'(tbl[i].e_whilo));
         chk($sformatf("vec%0d_hi", i), 64'(wb_hi), 64'(tbl[i].e_hi));
         chk($sformatf("vec%0d_lo", i), 64'(wb_lo), 64'(tbl[i].e_lo));
      end

      // Asynchronous reset mid-cycle with two entries loaded
      b = '{wdata: 32'hA, wd: 5'd1, wreg: 1'b1, whilo: 1'b0, hi: '0, lo: '0};
      drive(1, 0, 0, b);
      tick();
      b.wdata = 32'hB;
      drive(1, 0, 0, b);
      tick();
      drive(0, 0, 0, '0);
      chk("arst_pre_count", 64'(count), 2);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_count", 64'(count), 0);
      chk("arst_out_valid", 64'(out_valid), 0);
      chk("arst_wb_wreg", 64'(wb_wreg), 0);
      chk("arst_wb_wdata", 64'(wb_wdata), 0);
      tick();
      rst = 1'b1;
      chk("arst_rel_in_ready", 64'(in_ready), 1);
      b = '{wdata: 32'hC0FFEE, wd: 5'd3, wreg: 1'b1, whilo: 1'b0, hi: '0, lo: '0};
      drive(1, 0, 0, b);
      tick();
      chk("arst_first_push_count", 64'(count), 1);
      chk("arst_first_push_data", 64'(wb_wdata), 64'h00C0FFEE);
      drive(0, 1, 0, '0);
      tick();
      check_model("drain");

      // Wrap-around stream with toggling out_ready
      nxt = 1;
      got = 1;
      for (int cyc = 0; cyc < 60 && got <= 10; cyc++) begin
         b = '{wdata: DATA_W'(nxt), wd: ADDR_W'(nxt), wreg: 1'b1, whilo: 1'b0, hi: '0, lo: '0};
         drive(nxt <= 10, (cyc % 2) == 0, 0, b);
         if (out_valid && out_ready) begin
            chk("wrap_order", 64'(wb_wdata), 64'(got));
            got++;
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) nxt++;
         chk("wrap_cnt_max", 64'(count <= CNT_W'(DEPTH)), 1);
         check_model("wrap");
      end
      chk("wrap_done", 64'(got), 11);

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         b = '{wdata: $urandom, wd: ADDR_W'($urandom), wreg: 1'($urandom),
               whilo: 1'($urandom), hi: $urandom, lo: $urandom};
         drive(1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0, b);
         tick();
         check_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
